// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Four-master round-robin bus arbiter. Each owner may hold the bus for at
//   most QUANTUM cycles while another master is requesting. The owner can
//   extend its grant indefinitely by asserting its m_lock bit together with
//   its m_req bit. When nobody requests, the grant parks on the last owner.
//   Every output is driven directly from a flop, so the bus select never
//   glitches.
//
// Parameters
//   QUANTUM  maximum consecutive grant cycles under competition (1..15)
//   CNT_W    hold counter width; must be able to hold QUANTUM-1
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset (grant parks on master 0)
//   m_req     in   per-master bus request, level sensitive
//   m_lock    in   per-master lock; honoured only for a requesting owner
//   grant     out  one-hot grant, exactly one bit high at all times
//   grant_id  out  binary index of the granted master
//   handover  out  one-cycle pulse in the first cycle of a new owner's grant
//   hold_cnt  out  cycles held by the current owner, saturating at QUANTUM-1
module bus_rr_arbiter #(
  parameter int unsigned QUANTUM = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       m_req,
  input  logic [3:0]       m_lock,
  output logic [3:0]       grant,
  output logic [1:0]       grant_id,
  output logic             handover,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

  typedef enum logic [1:0] {
    ACT_KEEP,
    ACT_SWITCH,
    ACT_PARK
  } action_t;

  action_t          action;
  logic [1:0]       owner;
  logic [1:0]       owner_nxt;
  logic [3:0]       grant_q;
  logic [3:0]       grant_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             handover_q;
  logic             handover_nxt;
  logic [3:0]       others;
  logic             keep;
  logic [1:0]       rr_sel;
  logic             rr_found;

  // Competing requests exclude the current owner.
  assign others = m_req & ~grant_q;

  // The owner keeps the bus while requesting unless its quantum has expired
  // and someone else is waiting; a lock overrides the quantum.
  assign keep = m_req[owner] &&
                (m_lock[owner] || (others == '0) || (cnt < CNT_MAX));

  // Round-robin search starting just after the current owner.
  always_comb begin
    logic [1:0] cand;
    rr_sel   = owner;
    rr_found = 1'b0;
    cand     = owner;
    for (int unsigned i = 1; i < 4; i++) begin
      cand = owner + 2'(i);
      if (!rr_found && m_req[cand]) begin
        rr_sel   = cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    action = ACT_PARK;
    if (keep) begin
      action = ACT_KEEP;
    end else if (others != '0) begin
      action = ACT_SWITCH;
    end
  end

  always_comb begin
    owner_nxt    = owner;
    cnt_nxt      = '0;
    handover_nxt = 1'b0;
    unique case (action)
      ACT_KEEP: begin
        cnt_nxt = (cnt < CNT_MAX) ? cnt + 1'b1 : CNT_MAX;
      end
      ACT_SWITCH: begin
        owner_nxt    = rr_sel;
        handover_nxt = 1'b1;
      end
      ACT_PARK: begin
        // Grant stays on the last owner; counter restarts.
      end
      default: begin
      end
    endcase
    // One-hot is registered alongside the index so the select is glitch-free.
    grant_nxt = 4'b0001 << owner_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= '0;
      grant_q    <= 4'b0001;
      cnt        <= '0;
      handover_q <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      grant_q    <= grant_nxt;
      cnt        <= cnt_nxt;
      handover_q <= handover_nxt;
    end
  end

  assign grant    = grant_q;
  assign grant_id = owner;
  assign handover = handover_q;
  assign hold_cnt = cnt;

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Four-master round-robin bus arbiter with a per-owner hold quantum and lock override. It replaces the two-master arbiter FSM in front of the shared bus datapath. Its one-hot `grant` drives the master-side select of the address, write-enable and write-data muxes, and its `grant_id` feeds the slave read-data return path. All outputs are registered, so the bus select never glitches within a cycle.

## Interface
- `QUANTUM`, default 8: maximum consecutive grant cycles for an owner while another master requests. Legal range 1..15.
- `CNT_W`, default 4: width of the hold counter. Must hold the value `QUANTUM-1`.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `m_req`  in  4: bus request, one bit per master. Level-sensitive.
- `m_lock`  in  4: lock request, one bit per master. Honoured only for the current owner, and only while that owner's `m_req` is high.
- `grant`  out  4: one-hot grant. Exactly one bit is high at all times.
- `grant_id`  out  2: binary index of the granted master.
- `handover`  out  1: single-cycle pulse, high in the first cycle of a new owner's grant.
- `hold_cnt`  out  CNT_W: cycles the current owner has held the bus, saturating at `QUANTUM-1`.

## Operation
State:
- `owner` (2 bits).
- `cnt` (`CNT_W` bits).
- `handover` register.

Outputs:
- `grant = 1 << owner`, `grant_id = owner`, `hold_cnt = cnt`.
- All are decoded from registers; there is no combinational path from inputs to outputs.

Reset (`reset_n` = 0, asynchronous):
- `owner` = 0, so `grant` = 4'b0001 and `grant_id` = 0.
- `cnt` = 0, `handover` = 0.
- Master 0 is the park master.

Per rising edge, with `others = m_req & ~grant`:
- **KEEP** when `m_req[owner]` = 1 and at least one of the following holds:
  - `m_lock[owner]` = 1, or
  - `others` = 0, or
  - `cnt` < `QUANTUM-1`.
- On KEEP:
  - `owner` is unchanged.
  - `cnt` increments, saturating at `QUANTUM-1`.
  - `handover` = 0.
- **SWITCH** when KEEP is false and `others` ≠ 0:
  - The new owner is the first master with `m_req` set, scanning `owner+1`, `owner+2`, `owner+3` (mod 4).
  - `cnt` = 0, `handover` = 1.
- **PARK** when KEEP is false and `others` = 0. The owner is therefore not requesting and nobody else is.
  - `owner` is unchanged; the grant stays on the last owner.
  - `cnt` = 0, `handover` = 0.

Boundary rules:
- **Owner drops `m_req` while others request:** SWITCH at that same edge, regardless of `cnt`.
- **Lock:** `m_lock` held with `m_req` by the owner keeps the bus indefinitely. `cnt` keeps saturating during the lock. When the lock drops with `cnt` = `QUANTUM-1` and others requesting, SWITCH happens at the next edge.
- **Lock from a non-owner:** ignored.
- **`QUANTUM` = 1:** without lock, an owner holds for exactly one cycle whenever others request.
- **All four requesting continuously:** grants rotate 0→1→2→3→0, each for exactly `QUANTUM` cycles.
- **Park re-acquire:** a parked owner that re-asserts `m_req` with no competitor is KEEP. `cnt` counts up from 0 and `handover` stays 0.
- **Reset mid-grant:** the grant returns to master 0 immediately (asynchronously). Prior `cnt` and rotation position are lost.

## Timing
- **Request to grant latency:** a request sampled at edge k is reflected in `grant` after edge k, i.e. one cycle.
- **Fairness:** under continuous competition, an unlocked owner holds for exactly `QUANTUM` cycles. The worst-case wait for any continuously requesting master is `3*QUANTUM` cycles (no locks).
- **Pulse alignment:** `handover` is high for exactly one cycle, coincident with the first cycle of the new `grant` value.
- **Grant change point:** `grant` changes only at rising edges or on asynchronous reset assertion.
- **Master obligation:** a master samples its `grant` bit and drives the bus in the same cycle. The master holds `m_req` high until its transfer completes.

## Test plan
- **Reset state:** assert `reset_n`=0 mid-simulation with master 2 owning → `grant`=4'b0001, `grant_id`=0, `hold_cnt`=0, `handover`=0 immediately, without waiting for a clock edge.
- **Full rotation, `QUANTUM`=8:** `m_req`=4'b1111 continuously from reset → `grant` sequence 0001 (8 cycles), 0010 (8), 0100 (8), 1000 (8), 0001. `handover` pulses once per change.
- **Early release:** master 1 owns with `hold_cnt`=2; it drops `m_req` while `m_req[3]`=1 → next cycle `grant`=4'b1000, `hold_cnt`=0, `handover`=1. Master 2 (not requesting) is skipped.
- **Lock override:** master 0 owns with `m_lock[0]`=1 and `m_req`=4'b0011 for 20 cycles → `grant` stays 0001 and `hold_cnt` saturates at 7. Drop the lock → `grant`=0010 one cycle later.
- **Park:** master 3 owns, then `m_req`=0 → `grant` stays 1000, `hold_cnt`=0, no `handover`. Then assert `m_req`=4'b0100 → `grant`=0100 next cycle with `handover`=1.
- **`QUANTUM`=1:** run with `m_req`=4'b0101 continuously → `grant` alternates 0001/0100 every cycle, with `handover`=1 every cycle after the first switch.
